// File: rtl/request_arbiter.sv
// request_arbiter
//   Shares one resource among 8 requesters. While idle it picks one active
//   request and holds that grant until the owner drops its request or the
//   hold timeout fires. Every grant is followed by at least one idle cycle.
//
//   Arbitration policy:
//     default                    : fixed priority, highest set req index wins
//     `define ARB_ROUND_ROBIN_EN : rotating priority, downward search starting
//                                  at (last-1) mod 8, wrapping from 0 to 7
//
// Parameters
//   MAX_HOLD  max cycles a grant may be held, 0 = unlimited (legal 0..255)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   req[7:0]   in   request vector, bit i = requester i wants the resource
//   gnt[7:0]   out  one-hot grant, zero when no grant
//   gnt_id[2:0]out  binary index of the granted requester, 0 when no grant
//   gnt_valid  out  high while a grant is held
//   timeout    out  one-cycle pulse when a grant is revoked by MAX_HOLD
//
// All outputs come straight from registers; req only feeds next-state logic.
module request_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] MAX_HOLD_C   = 8'(MAX_HOLD);
    localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg,    state_next;
    logic [7:0] gnt_reg,      gnt_next;
    logic [2:0] gnt_id_reg,   gnt_id_next;
    logic       timeout_reg,  timeout_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;

    // Search order: cand_idx[0] is examined first, cand_idx[7] last.
    logic [2:0] cand_idx [8];
    logic       win_found;
    logic [2:0] win_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] last_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cand
            // 3-bit subtraction wraps naturally from 0 to 7.
            assign cand_idx[gi] = last_reg - 3'(gi + 1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= 3'd0;
        end else if (state_reg == IDLE && win_found) begin
            last_reg <= win_id;
        end
    end
`else
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cand
            assign cand_idx[gi] = 3'(7 - gi);
        end
    endgenerate
`endif

    // First set request in search order wins. Iterating from the back lets
    // earlier candidates overwrite later ones.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                win_found = 1'b1;
                win_id    = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        timeout_next  = 1'b0;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next    = GRANT;
                    gnt_next      = 8'd1 << win_id;
                    gnt_id_next   = win_id;
                    hold_cnt_next = 8'd1;
                end
            end
            GRANT: begin
                // Release is checked first so it wins over a coincident timeout.
                if (!req[gnt_id_reg]) begin
                    state_next    = IDLE;
                    gnt_next      = 8'd0;
                    gnt_id_next   = 3'd0;
                    hold_cnt_next = 8'd0;
                end else if (HOLD_LIMITED && hold_cnt_reg == MAX_HOLD_C) begin
                    state_next    = IDLE;
                    gnt_next      = 8'd0;
                    gnt_id_next   = 3'd0;
                    hold_cnt_next = 8'd0;
                    timeout_next  = 1'b1;
                end else if (hold_cnt_reg != 8'hFF) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            gnt_reg      <= 8'd0;
            gnt_id_reg   <= 3'd0;
            timeout_reg  <= 1'b0;
            hold_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            timeout_reg  <= timeout_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = (state_reg == GRANT);
    assign timeout   = timeout_reg;

endmodule
